// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto one single-port RAM, data side first.
// Optional access watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MAX_DSTREAK = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic              iwait,
   output logic [DATA_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   output logic              dwait,
   output logic [DATA_W-1:0] dload,
   output logic              ram_ren,
   output logic              ram_wen,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_store,
   input  logic [DATA_W-1:0] ram_load,
   input  logic              ram_ready,
   output logic              timeout_err
);

   localparam int SW = $clog2(MAX_DSTREAK + 1);

   if (MAX_DSTREAK < 1 || TIMEOUT_CYC < 1) begin : g_cfg_chk
      $error("mem_arbiter: MAX_DSTREAK and TIMEOUT_CYC must be >= 1");
   end

   typedef enum logic [1:0] {
      IDLE,
      IACC,
      DACC,
      RESP
   } state_e;

   state_e            state_q, state_d;
   logic [SW-1:0]     streak_q, streak_d;
   logic              gnt_q, gnt_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] store_q, store_d;
   logic [DATA_W-1:0] iload_q, iload_d;
   logic [DATA_W-1:0] dload_q, dload_d;
   logic              iwait_q, iwait_d;
   logic              dwait_q, dwait_d;
   logic              terr_q, terr_d;
   logic              d_pend;
   logic              in_acc;

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [DATA_W-1:0] BAD = DATA_W'(32'hBAD1_BAD1);
   logic [CW-1:0]     cnt_q, cnt_d;
`endif

   assign d_pend = dREN | dWEN;
   assign in_acc = (state_q == IACC) || (state_q == DACC);

   // Strobes come straight from the latched access registers.
   assign ram_ren     = in_acc && !we_q;
   assign ram_wen     = in_acc && we_q;
   assign ram_addr    = addr_q;
   assign ram_store   = store_q;
   assign iwait       = iwait_q;
   assign dwait       = dwait_q;
   assign iload       = iload_q;
   assign dload       = dload_q;
   assign timeout_err = terr_q;

   // Next-state, grant latching, streak and load capture.
   always_comb begin
      state_d  = state_q;
      streak_d = streak_q;
      gnt_d    = gnt_q;
      we_d     = we_q;
      addr_d   = addr_q;
      store_d  = store_q;
      iload_d  = iload_q;
      dload_d  = dload_q;
      terr_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_d    = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (d_pend && (!iREN || streak_q < SW'(MAX_DSTREAK))) begin
               state_d = DACC;
               gnt_d   = 1'b1;
               we_d    = dWEN;
               addr_d  = daddr;
               store_d = dstore;
               if (!iREN)
                  streak_d = '0;
               else if (streak_q != SW'(MAX_DSTREAK))
                  streak_d = streak_q + 1'b1;
`ifdef ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end else if (iREN) begin
               state_d  = IACC;
               gnt_d    = 1'b0;
               we_d     = 1'b0;
               addr_d   = iaddr;
               streak_d = '0;
`ifdef ARB_TIMEOUT_EN
               cnt_d    = '0;
`endif
            end
         end
         IACC, DACC: begin
            if (ram_ready) begin
               state_d = RESP;
               if (!we_q) begin
                  if (gnt_q) dload_d = ram_load;
                  else       iload_d = ram_load;
               end
            end
`ifdef ARB_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
               state_d = RESP;
               terr_d  = 1'b1;
               if (gnt_q) dload_d = BAD;
               else       iload_d = BAD;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      iwait_d = !(state_d == RESP && !gnt_d);
      dwait_d = !(state_d == RESP && gnt_d);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= IDLE;
         streak_q <= '0;
         gnt_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         store_q  <= '0;
         iload_q  <= '0;
         dload_q  <= '0;
         iwait_q  <= 1'b1;
         dwait_q  <= 1'b1;
         terr_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         streak_q <= streak_d;
         gnt_q    <= gnt_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         store_q  <= store_d;
         iload_q  <= iload_d;
         dload_q  <= dload_d;
         iwait_q  <= iwait_d;
         dwait_q  <= dwait_d;
         terr_q   <= terr_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

endmodule
